// File: rtl/regfile_wb_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_sequencer
//  Purpose  : Write-port controller for the 32x32 register file: clears every
//             register after reset, then round-robins writebacks from A and B.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_sequencer #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              soft_clear,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              RegWrite,
    output logic              wb_src,
    output logic              init_done
);

    localparam logic [0:0]      S_INIT = 1'b0;
    localparam logic [0:0]      S_RUN  = 1'b1;
    localparam logic [ADDR_W:0] c_last = (ADDR_W+1)'(NUM_REGS - 1);

    logic [0:0]        r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_prio;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic              r_reg_write;
    logic              r_wb_src;
    logic              r_init_done;

    logic w_block;
    logic w_grant_a;
    logic w_grant_b;

    // Grants open only once init_done is visible, so no writeback can race
    // the cycle that retires the last clear write.
    assign w_block   = !r_init_done || soft_clear;
    assign w_grant_a = !w_block && a_valid && (!b_valid || !r_prio);
    assign w_grant_b = !w_block && b_valid && (!a_valid ||  r_prio);

    assign a_ready    = w_grant_a;
    assign b_ready    = w_grant_b;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;
    assign RegWrite   = r_reg_write;
    assign wb_src     = r_wb_src;
    assign init_done  = r_init_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_INIT;
            r_cnt        <= '0;
            r_prio       <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_reg_write  <= 1'b0;
            r_wb_src     <= 1'b0;
            r_init_done  <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_reg_write  <= 1'b1;
                    r_write_reg  <= r_cnt[ADDR_W-1:0];
                    r_write_data <= '0;
                    r_wb_src     <= 1'b0;
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (soft_clear) begin
                        r_state     <= S_INIT;
                        r_cnt       <= '0;
                        r_init_done <= 1'b0;
                        r_reg_write <= 1'b0;
                        r_prio      <= 1'b0;
                    end else begin
                        r_init_done <= 1'b1;
                        if (w_grant_a) begin
                            r_write_reg  <= a_reg;
                            r_write_data <= a_data;
                            r_wb_src     <= 1'b0;
                            r_reg_write  <= (a_reg != '0);
                            r_prio       <= 1'b1;
                        end else if (w_grant_b) begin
                            r_write_reg  <= b_reg;
                            r_write_data <= b_data;
                            r_wb_src     <= 1'b1;
                            r_reg_write  <= (b_reg != '0);
                            r_prio       <= 1'b0;
                        end else begin
                            r_reg_write <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
